debugger_rx: RTL and testbench
==============================

Name: debugger_rx

Overview:
- Receive side of the UART debugger link.
- Consumes bytes from the UART receiver and decodes single-byte host commands: run, pause, step, CPU reset, frame dump request.
- Executes a program-load command that streams 32-bit words into instruction memory.
- Sits between the UART RX core and the MIPS core / instruction memory. Its send_request pulse triggers the debugger transmitter's frame dump.

Parameters:
- ADDR_W, 10, instruction memory word-address width; load depth = 2^ADDR_W words.
- TIMEOUT_CYCLES, 5000000, maximum idle clk cycles between bytes inside a load before it is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse; r_data holds a valid byte.
- r_data  in  8  received byte.
- dataSent  in  1  from the debugger transmitter; 1 = transmitter idle.
- imem_we  out  1  instruction memory write strobe (one-cycle pulse).
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_run  out  1  level; 1 = CPU free-running.
- cpu_step  out  1  one-cycle pulse: advance CPU one clock.
- cpu_reset  out  1  one-cycle pulse: reset the CPU pipeline.
- send_request  out  1  one-cycle pulse: start a frame dump.
- load_done  out  1  one-cycle pulse: load completed successfully.
- cmd_error  out  1  one-cycle pulse: protocol error.
- state_reg_rx  out  3  current FSM state, for debug LEDs.

Behaviour:
- All outputs are registered. Any response to a byte appears on the cycle after its rx_done_tick is sampled.
- Reset: all outputs 0, imem_addr = 0, imem_wdata = 0, state = IDLE, counters cleared.
- Reset asserted mid-load aborts the load. No further imem_we is issued. Words already written are not rolled back.
- States:
  - IDLE = 3'd0
  - CNT_HI = 3'd1
  - CNT_LO = 3'd2
  - DATA = 3'd3
  - FINISH = 3'd4
- IDLE decodes the byte on rx_done_tick:
  - 0x43 'C': cpu_run <= 1.
  - 0x50 'P': cpu_run <= 0.
  - 0x53 'S': if cpu_run = 0, pulse cpu_step; if cpu_run = 1, pulse cmd_error.
  - 0x52 'R': pulse cpu_reset.
  - 0x44 'D': if dataSent = 1, pulse send_request; otherwise pulse cmd_error.
  - 0x4C 'L': cpu_run <= 0, go to CNT_HI.
  - Any other value: pulse cmd_error, stay in IDLE.
- CNT_HI: byte becomes word_count[15:8]; go to CNT_LO.
- CNT_LO: byte becomes word_count[7:0]. Then:
  - word_count = 0: go to FINISH.
  - word_count > 2^ADDR_W: pulse cmd_error, return to IDLE, no writes issued.
  - Otherwise: clear word index and byte index, go to DATA.
- DATA:
  - Bytes arrive MSB-first, the same order the transmitter uses.
  - The shift register shifts left 8 bits and inserts r_data in bits [7:0].
  - On the 4th byte of a word: imem_wdata = assembled word, imem_addr = word index, imem_we = 1 for one cycle.
  - After the write, word index increments and byte index wraps to 0.
  - After the write of word word_count-1, go to FINISH.
- FINISH: pulse load_done for one cycle, return to IDLE. cpu_run stays 0.
- Timeout:
  - Inter-byte counter clears on every rx_done_tick and runs in CNT_HI, CNT_LO and DATA.
  - When it reaches TIMEOUT_CYCLES-1: pulse cmd_error, return to IDLE.
  - A partial word is discarded, never written.
- Load addresses always start at 0 and never exceed 2^ADDR_W-1, so no wrap-around can occur.
- During a load, command bytes are data, not commands (e.g. 0x43 inside DATA is payload).
- Simultaneous events: rx_done_tick on the same cycle as a timeout expiry — the byte wins and the counter clears.
- At most one of cpu_step, cpu_reset, send_request, load_done, cmd_error is high in any cycle.

Decomposition:
- Shared package debugger_pkg holds:
  - command byte constants: CMD_RUN, CMD_PAUSE, CMD_STEP, CMD_RESET, CMD_DUMP, CMD_LOAD;
  - state encodings;
  - the 32-bit word width.
- One natural sub-module: debugger_word_assembler, covering the byte shift register, byte index and word-complete strobe, with a clear input for abort.
- The timeout counter stays inline.

Test Plan:
1. 'C', then 'S' -> cpu_run = 1, then one cmd_error pulse and no cpu_step. 'P', then 'S' -> cpu_run = 0, then one cpu_step pulse.
2. 'L', 0x00, 0x02, 20 01 00 05, AC 01 00 04 -> imem_we at addr 0 with 0x20010005 and at addr 1 with 0xAC010004; load_done one cycle after the second write; cpu_run = 0.
3. Byte 0x7A in IDLE -> single cmd_error pulse, state stays 0. 'D' with dataSent = 0 -> cmd_error; 'D' with dataSent = 1 -> send_request.
4. 'L', 0x00, 0x01, 0x12, 0x34, then silence for TIMEOUT_CYCLES (override to 100) -> cmd_error at cycle 100, no imem_we, next 'C' is decoded as a command.
5. With ADDR_W = 4: 'L', 0x00, 0x11 -> cmd_error, no writes. 'L', 0x00, 0x00 -> load_done, no writes.
6. Reset asserted after 2 data bytes of a load -> next cycle all outputs 0, state IDLE; following 'R' -> cpu_reset pulse.

Source files
------------

// File: rtl/debugger_pkg.sv
// debugger_pkg: command bytes, receive FSM states and word width shared by the debugger RX path.
package debugger_pkg;
  localparam int WORD_W = 32;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4
  } state_t;
endpackage

// File: rtl/debugger_word_assembler.sv
// debugger_word_assembler: packs MSB-first bytes into words and flags the fourth byte of each word.
module debugger_word_assembler
  import debugger_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              done
);
  logic [WORD_W-9:0] shreg;
  logic [1:0]        idx;
  assign word = {shreg, data};
  assign done = en && idx == 2'd3;
  always_ff @(posedge clk)
    if (reset || clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (en) begin
      shreg <= word[WORD_W-9:0];
      idx   <= idx + 2'd1;
    end
endmodule

// File: rtl/debugger_rx.sv
// debugger_rx: decodes host command bytes and streams program-load words into instruction memory.
module debugger_rx
  import debugger_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        r_data,
  input  logic              dataSent,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              cpu_step,
  output logic              cpu_reset,
  output logic              send_request,
  output logic              load_done,
  output logic              cmd_error,
  output logic [2:0]        state_reg_rx
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  state_t            state, state_d;
  logic [15:0]       word_count, count_d, count_lo;
  logic [ADDR_W-1:0] widx, widx_d;
  logic [TW-1:0]     tcnt;
  logic              run_d, step_d, creset_d, send_d, done_d, err_d, we_d;
  logic              loading, timeout, too_big, last, word_done;
  logic [WORD_W-1:0] word;
  assign state_reg_rx = state;
  assign loading  = state == CNT_HI || state == CNT_LO || state == DATA;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout  = loading && !rx_done_tick && tcnt == T_MAX;
  assign count_lo = {word_count[15:8], r_data};
  assign too_big  = {1'b0, count_lo} > MAX_WORDS;
  assign last     = 17'(widx) + 17'd1 == {1'b0, word_count};
  debugger_word_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (state != DATA || timeout),
    .en    (rx_done_tick && state == DATA),
    .data  (r_data),
    .word  (word),
    .done  (word_done)
  );
  always_comb begin
    state_d  = state;
    run_d    = cpu_run;
    step_d   = 1'b0;
    creset_d = 1'b0;
    send_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we_d     = 1'b0;
    count_d  = word_count;
    widx_d   = widx;
    case (state)
      IDLE: if (rx_done_tick)
        case (r_data)
          CMD_RUN:   run_d = 1'b1;
          CMD_PAUSE: run_d = 1'b0;
          CMD_STEP:  begin step_d = !cpu_run; err_d = cpu_run; end
          CMD_RESET: creset_d = 1'b1;
          CMD_DUMP:  begin send_d = dataSent; err_d = !dataSent; end
          CMD_LOAD:  begin run_d = 1'b0; state_d = CNT_HI; end
          default:   err_d = 1'b1;
        endcase
      CNT_HI: if (rx_done_tick) begin
        count_d = {r_data, 8'h00};
        state_d = CNT_LO;
      end
      CNT_LO: if (rx_done_tick) begin
        count_d = count_lo;
        err_d   = too_big;
        widx_d  = '0;
        state_d = count_lo == '0 ? FINISH : too_big ? IDLE : DATA;
      end
      DATA: if (word_done) begin
        we_d    = 1'b1;
        widx_d  = widx + ADDR_W'(1);
        state_d = last ? FINISH : DATA;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      cpu_run      <= 1'b0;
      cpu_step     <= 1'b0;
      cpu_reset    <= 1'b0;
      send_request <= 1'b0;
      load_done    <= 1'b0;
      cmd_error    <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      word_count   <= '0;
      widx         <= '0;
      tcnt         <= '0;
    end else begin
      state        <= state_d;
      cpu_run      <= run_d;
      cpu_step     <= step_d;
      cpu_reset    <= creset_d;
      send_request <= send_d;
      load_done    <= done_d;
      cmd_error    <= err_d;
      imem_we      <= we_d;
      word_count   <= count_d;
      widx         <= widx_d;
      tcnt         <= (rx_done_tick || !loading) ? '0 : tcnt + TW'(1);
      if (we_d) begin
        imem_addr  <= widx;
        imem_wdata <= word;
      end
    end
endmodule

// File: tb/tb_debugger_rx.sv
// tb_debugger_rx: directed command/load vectors with an expected-event queue checked by a monitor.
module tb_debugger_rx;
  localparam int AW = 4;
  localparam int EV_STEP = 0, EV_RST = 1, EV_SEND = 2, EV_DONE = 3, EV_ERR = 4, EV_WE = 5;
  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic [31:0] data;
    bit          after_we;
  } ev_t;
  logic clk = 1'b0, reset = 1'b1, rx_done_tick = 1'b0, dataSent = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic imem_we, cpu_run, cpu_step, cpu_reset, send_request, load_done, cmd_error;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0] state_reg_rx;
  int compared = 0, mismatched = 0;
  ev_t exp_q[$];
  bit prev_we = 1'b0;
  debugger_rx #(.ADDR_W(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .dataSent(dataSent), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .cpu_step(cpu_step),
    .cpu_reset(cpu_reset), .send_request(send_request), .load_done(load_done),
    .cmd_error(cmd_error), .state_reg_rx(state_reg_rx)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic observe(input int k);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL event: got unexpected kind %0d addr %h data %h", k, imem_addr, imem_wdata);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_WE && (e.addr !== imem_addr || e.data !== imem_wdata)) ||
          (e.after_we && !prev_we)) begin
        mismatched++;
        $display("FAIL event: got kind %0d addr %h data %h prev_we %0d, expected kind %0d addr %h data %h after_we %0d",
                 k, imem_addr, imem_wdata, prev_we, e.kind, e.addr, e.data, e.after_we);
      end
    end
  endtask
  always @(negedge clk) begin
    int n;
    n = int'(cpu_step) + int'(cpu_reset) + int'(send_request) + int'(load_done) + int'(cmd_error);
    if (n > 0) begin
      compared++;
      if (n > 1) begin
        mismatched++;
        $display("FAIL pulse_exclusive: got %0d pulses, expected at most 1", n);
      end
    end
    if (cpu_step)     observe(EV_STEP);
    if (cpu_reset)    observe(EV_RST);
    if (send_request) observe(EV_SEND);
    if (load_done)    observe(EV_DONE);
    if (cmd_error)    observe(EV_ERR);
    if (imem_we)      observe(EV_WE);
    prev_we = imem_we;
  end
  task automatic expect_ev(input int k, input logic [AW-1:0] a = '0, input logic [31:0] d = '0, input bit aw = 1'b0);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.after_we = aw;
    exp_q.push_back(e);
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    r_data = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_idle_outputs(input string name);
    chk({name, "_state"}, state_reg_rx, 0);
    chk({name, "_run"}, cpu_run, 0);
    chk({name, "_pulses"}, {imem_we, cpu_step, cpu_reset, send_request, load_done, cmd_error}, 0);
    chk({name, "_addr"}, imem_addr, 0);
    chk({name, "_wdata"}, imem_wdata, 0);
  endtask
  initial begin
    int cnt;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_outputs("reset");
    send_byte(8'h43);
    chk("run_after_C", cpu_run, 1);
    expect_ev(EV_ERR);
    send_byte(8'h53);
    drain("step_while_running");
    send_byte(8'h50);
    chk("run_after_P", cpu_run, 0);
    expect_ev(EV_STEP);
    send_byte(8'h53);
    drain("step_while_paused");
    send_byte(8'h43);
    send_byte(8'h4C);
    chk("load_state_cnt_hi", state_reg_rx, 1);
    chk("load_clears_run", cpu_run, 0);
    send_byte(8'h00);
    chk("load_state_cnt_lo", state_reg_rx, 2);
    send_byte(8'h02);
    chk("load_state_data", state_reg_rx, 3);
    expect_ev(EV_WE, 0, 32'h20010005);
    expect_ev(EV_WE, 1, 32'hAC010004);
    expect_ev(EV_DONE, 0, 0, 1'b1);
    send_word(32'h20010005);
    send_word(32'hAC010004);
    drain("load_two");
    chk("load_two_state", state_reg_rx, 0);
    chk("load_two_run", cpu_run, 0);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
    expect_ev(EV_WE, 0, 32'h4C435344);
    expect_ev(EV_DONE, 0, 0, 1'b1);
    send_word(32'h4C435344);
    drain("load_cmd_payload");
    chk("payload_not_cmd_run", cpu_run, 0);
    expect_ev(EV_ERR);
    send_byte(8'h7A);
    chk("bad_cmd_state", state_reg_rx, 0);
    dataSent = 1'b0;
    expect_ev(EV_ERR);
    send_byte(8'h44);
    dataSent = 1'b1;
    expect_ev(EV_SEND);
    send_byte(8'h44);
    drain("dump");
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
    expect_ev(EV_ERR);
    cnt = 0;
    while (!cmd_error && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, 100);
    drain("timeout");
    chk("timeout_state", state_reg_rx, 0);
    send_byte(8'h43);
    chk("cmd_after_timeout", cpu_run, 1);
    expect_ev(EV_ERR);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h11);
    drain("count_too_big");
    chk("count_too_big_state", state_reg_rx, 0);
    expect_ev(EV_DONE);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    drain("count_zero");
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      w = {8'hA0 + 8'(i), 8'h11, 8'h22, 8'h30 + 8'(i)};
      expect_ev(EV_WE, AW'(i), w);
      send_word(w);
    end
    expect_ev(EV_DONE, 0, 0, 1'b1);
    drain("count_full_depth");
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("mid_load_reset");
    reset = 1'b0;
    expect_ev(EV_RST);
    send_byte(8'h52);
    drain("cpu_reset");
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
